// File: rtl/xor_ctrl_pkg.sv
// rtl/xor_ctrl_pkg.sv - shared state encoding, default sizes and output decode for the xor sequencer
package xor_ctrl_pkg;

  localparam int KEY_SIZE_D = 4;
  localparam int MSG_SIZE_D = 8;
  localparam int TIMEOUT_D  = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_KEY  = 3'd1,
    ST_LOAD_MSG  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_STREAM    = 3'd4,
    ST_FINISH    = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  typedef struct packed {
    logic en;
    logic load_key;
    logic load_msg;
    logic bit_req;
    logic out_valid;
    logic frame_done;
    logic busy;
    logic err;
  } ctrl_out_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Moore decode: every output is a pure function of the state.
  function automatic ctrl_out_t decode_state(input state_t s);
    ctrl_out_t o;
    o = '0;
    o.busy = (s != ST_IDLE);
    case (s)
      ST_LOAD_KEY: begin
        o.en       = 1'b1;
        o.load_key = 1'b1;
        o.bit_req  = 1'b1;
      end
      ST_LOAD_MSG: begin
        o.en       = 1'b1;
        o.load_msg = 1'b1;
        o.bit_req  = 1'b1;
      end
      ST_WAIT_DONE: o.en = 1'b1;
      ST_STREAM: begin
        o.en        = 1'b1;
        o.out_valid = 1'b1;
      end
      ST_FINISH: o.frame_done = 1'b1;
      ST_ERROR:  o.err        = 1'b1;
      default:   o.busy       = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/xor_seq_ctrl_if.sv
// rtl/xor_seq_ctrl_if.sv - host/datapath handshake bundle for the xor sequencer
interface xor_seq_ctrl_if;

  logic iStart;
  logic iAbort;
  logic iKey_reuse;
  logic iDone_flag;
  logic oEn;
  logic oLoad_key;
  logic oLoad_msg;
  logic oBit_req;
  logic oOut_valid;
  logic oFrame_done;
  logic oBusy;
  logic oErr;

  modport master (
    output iStart, iAbort, iKey_reuse, iDone_flag,
    input  oEn, oLoad_key, oLoad_msg, oBit_req, oOut_valid, oFrame_done, oBusy, oErr
  );

  modport slave (
    input  iStart, iAbort, iKey_reuse, iDone_flag,
    output oEn, oLoad_key, oLoad_msg, oBit_req, oOut_valid, oFrame_done, oBusy, oErr
  );

endinterface

// File: rtl/xor_seq_ctrl_counter.sv
// rtl/xor_seq_ctrl_counter.sv - phase counter with sync clear, enable and terminal-count compare
module ctrl_counter #(
  parameter int W = 6
) (
  input  logic         oClk_slow,
  input  logic         iRst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge oClk_slow or negedge iRst) begin
    if (!iRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/xor_seq_ctrl.sv
// rtl/xor_seq_ctrl.sv - frame sequencer driving key/message load, wait-for-done and ciphertext window
module xor_seq_ctrl
  import xor_ctrl_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_D,
  parameter int MSG_SIZE = MSG_SIZE_D,
  parameter int TIMEOUT  = TIMEOUT_D
) (
  input  logic          oClk_slow,
  input  logic          iRst,
  xor_seq_ctrl_if.slave bus
);

  localparam int CNT_MAX = max3(KEY_SIZE, MSG_SIZE, TIMEOUT);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t       state_q;
  state_t       state_d;
  logic         key_valid_q;
  logic         key_valid_d;
  ctrl_out_t    out_q;
  ctrl_out_t    out_d;
  logic         cnt_clr;
  logic         cnt_en;
  logic         tc;
  logic [CW-1:0] tc_val;

  always_comb begin
    tc_val = '0;
    case (state_q)
      ST_LOAD_KEY:             tc_val = CW'(KEY_SIZE - 1);
      ST_LOAD_MSG, ST_STREAM:  tc_val = CW'(MSG_SIZE - 1);
      ST_WAIT_DONE:            tc_val = CW'(TIMEOUT - 1);
      default:                 tc_val = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    if (bus.iAbort) begin
      state_d     = ST_IDLE;
      key_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iStart) begin
            state_d = (bus.iKey_reuse && key_valid_q) ? ST_LOAD_MSG : ST_LOAD_KEY;
          end
        end
        ST_LOAD_KEY: begin
          if (tc) begin
            key_valid_d = 1'b1;
            state_d     = ST_LOAD_MSG;
          end
        end
        ST_LOAD_MSG: begin
          if (tc) state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // done on the timeout cycle still counts as success
          if (bus.iDone_flag) state_d = ST_STREAM;
          else if (tc)        state_d = ST_ERROR;
        end
        ST_STREAM: begin
          if (tc) state_d = ST_FINISH;
        end
        ST_FINISH: state_d = ST_IDLE;
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Every phase starts its count from zero; terminal counts always leave the state, so no wrap.
  always_comb begin
    cnt_clr = bus.iAbort || (state_d != state_q);
    cnt_en  = 1'b0;
    case (state_q)
      ST_LOAD_KEY, ST_LOAD_MSG, ST_WAIT_DONE, ST_STREAM: cnt_en = !cnt_clr;
      default: cnt_en = 1'b0;
    endcase
  end

  ctrl_counter #(.W(CW)) u_cnt (
    .oClk_slow (oClk_slow),
    .iRst      (iRst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .tc_val    (tc_val),
    .tc        (tc)
  );

  // outputs are registered from the next state so they track the state register exactly
  always_comb begin
    out_d = decode_state(state_d);
  end

  always_ff @(posedge oClk_slow or negedge iRst) begin
    if (!iRst) begin
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.oEn         = out_q.en;
  assign bus.oLoad_key   = out_q.load_key;
  assign bus.oLoad_msg   = out_q.load_msg;
  assign bus.oBit_req    = out_q.bit_req;
  assign bus.oOut_valid  = out_q.out_valid;
  assign bus.oFrame_done = out_q.frame_done;
  assign bus.oBusy       = out_q.busy;
  assign bus.oErr        = out_q.err;

endmodule

// File: tb/tb_xor_seq_ctrl.sv
// tb/tb_xor_seq_ctrl.sv - directed and random checks of xor_seq_ctrl against a frame-plan model
module tb_xor_seq_ctrl;

  localparam int KEY_N = 4;
  localparam int MSG_N = 8;
  localparam int TMO_N = 64;

  // phase labels used by the model's plan queue
  localparam int M_IDLE = 0;
  localparam int M_KEY  = 1;
  localparam int M_MSG  = 2;
  localparam int M_WAIT = 3;
  localparam int M_STRM = 4;
  localparam int M_FIN  = 5;
  localparam int M_ERR  = 6;

  logic clk;
  logic rst_n;

  xor_seq_ctrl_if bus ();

  xor_seq_ctrl #(.KEY_SIZE(KEY_N), .MSG_SIZE(MSG_N), .TIMEOUT(TMO_N)) dut (
    .oClk_slow (clk),
    .iRst      (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int plan[$];
  int cur      = M_IDLE;
  int wait_n   = 0;
  bit key_held = 1'b0;

  int busy_cnt = 0;
  int fd_cnt   = 0;
  string phase = "reset";

  function automatic logic [7:0] exp_of(input int c);
    logic en, lk, lm, ov, fd, er;
    en = (c == M_KEY) || (c == M_MSG) || (c == M_WAIT) || (c == M_STRM);
    lk = (c == M_KEY);
    lm = (c == M_MSG);
    ov = (c == M_STRM);
    fd = (c == M_FIN);
    er = (c == M_ERR);
    return {en, lk, lm, lk | lm, ov, fd, c != M_IDLE, er};
  endfunction

  function automatic logic [7:0] sample();
    return {bus.oEn, bus.oLoad_key, bus.oLoad_msg, bus.oBit_req,
            bus.oOut_valid, bus.oFrame_done, bus.oBusy, bus.oErr};
  endfunction

  task automatic model_reset();
    plan.delete();
    cur      = M_IDLE;
    wait_n   = 0;
    key_held = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit r, input bit d);
    int prev;
    if (!rst_n) begin
      model_reset();
    end else if (a) begin
      plan.delete();
      cur      = M_IDLE;
      key_held = 1'b0;
    end else if (cur == M_ERR) begin
      cur = M_ERR;
    end else if (cur == M_WAIT) begin
      if (d) begin
        repeat (MSG_N) plan.push_back(M_STRM);
        plan.push_back(M_FIN);
        cur = plan.pop_front();
      end else if (wait_n == TMO_N) begin
        cur = M_ERR;
      end else begin
        wait_n++;
      end
    end else if (cur == M_FIN) begin
      cur = M_IDLE;
    end else if (cur == M_IDLE) begin
      if (s) begin
        if (!(r && key_held)) repeat (KEY_N) plan.push_back(M_KEY);
        repeat (MSG_N) plan.push_back(M_MSG);
        plan.push_back(M_WAIT);
        cur = plan.pop_front();
      end
    end else begin
      prev = cur;
      cur  = plan.pop_front();
      if (prev == M_KEY && cur != M_KEY) key_held = 1'b1;
      if (cur == M_WAIT) wait_n = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cyc(input bit s, input bit a, input bit r, input bit d);
    logic [7:0] obs;
    bus.iStart     = s;
    bus.iAbort     = a;
    bus.iKey_reuse = r;
    bus.iDone_flag = d;
    @(posedge clk);
    model_step(s, a, r, d);
    @(negedge clk);
    obs = sample();
    chk(phase, obs, exp_of(cur));
    chk("inv_load_excl", {7'b0, obs[6] & obs[5]}, 8'h00);
    chk("inv_en_off", {7'b0, obs[7] & (!obs[1] | obs[2] | obs[0])}, 8'h00);
    busy_cnt += int'(obs[1]);
    fd_cnt   += int'(obs[2]);
  endtask

  task automatic run(input int n, input bit s, input bit a, input bit r, input bit d);
    repeat (n) cyc(s, a, r, d);
  endtask

  task automatic finish_frame();
    for (int k = 0; k < 100 && bus.oBusy; k++) cyc(0, 0, 0, 1);
    chk("finish_idle", {7'b0, bus.oBusy}, 8'h00);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.iStart     = 1'b0;
    bus.iAbort     = 1'b0;
    bus.iKey_reuse = 1'b0;
    bus.iDone_flag = 1'b0;
    @(negedge clk);
    run(3, 0, 0, 0, 0);
    chk("reset_outputs", sample(), 8'h00);
    rst_n = 1'b1;
    run(2, 0, 0, 0, 0);

    // 1: full frame, done on the third WAIT_DONE cycle
    phase = "t1_frame";
    busy_cnt = 0;
    cyc(1, 0, 0, 0);
    run(11, 0, 0, 0, 0);
    run(3, 0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    run(8, 0, 0, 0, 0);
    run(2, 0, 0, 0, 0);
    chk("t1_frame_len", 8'(busy_cnt), 8'd24);

    // 2: key reuse skips key load
    phase = "t2_reuse";
    cyc(1, 0, 1, 0);
    chk("t2_first_strobe", {6'b0, bus.oLoad_key, bus.oLoad_msg}, 8'h01);
    run(7, 0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    finish_frame();

    // 3: timeout into ERROR, start ignored, abort recovers
    phase = "t3_timeout";
    cyc(1, 0, 0, 0);
    run(11, 0, 0, 0, 0);
    run(64, 0, 0, 0, 0);
    chk("t3_no_err_yet", {7'b0, bus.oErr}, 8'h00);
    cyc(0, 0, 0, 0);
    chk("t3_err", {7'b0, bus.oErr}, 8'h01);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 0);
    chk("t3_abort_clr", {bus.oErr, bus.oBusy}, 2'b00);

    // 4: abort in LOAD_MSG cycle 5 clears key_valid
    phase = "t4_abort";
    cyc(1, 0, 0, 0);
    run(3, 0, 0, 0, 0);
    run(5, 0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t4_strobes_off", {5'b0, bus.oLoad_key, bus.oLoad_msg, bus.oEn}, 8'h00);
    cyc(1, 0, 1, 0);
    chk("t4_key_reload", {7'b0, bus.oLoad_key}, 8'h01);
    finish_frame();

    // 5: start held high runs one frame, next frame one cycle after IDLE
    phase = "t5_held";
    fd_cnt = 0;
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 60 && !bus.oFrame_done; k++) cyc(1, 0, 0, 1);
    chk("t5_one_frame", 8'(fd_cnt), 8'd1);
    cyc(1, 0, 0, 1);
    chk("t5_idle_gap", {7'b0, bus.oBusy}, 8'h00);
    cyc(1, 0, 0, 1);
    chk("t5_restart", {7'b0, bus.oLoad_key}, 8'h01);
    cyc(0, 1, 0, 0);

    // 6: asynchronous reset during STREAM
    phase = "t6_async";
    cyc(1, 0, 0, 0);
    run(11, 0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    run(2, 0, 0, 0, 0);
    chk("t6_in_stream", {7'b0, bus.oOut_valid}, 8'h01);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rst", sample(), 8'h00);
    model_reset();
    @(negedge clk);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(1, 0, 1, 0);
    chk("t6_key_after_rst", {7'b0, bus.oLoad_key}, 8'h01);
    finish_frame();

    // random traffic; done is sparse in alternate blocks so timeouts occur
    phase = "rand";
    for (int i = 0; i < 3000; i++) begin
      bit s, a, r, d;
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 99) == 0);
      r = 1'($urandom_range(0, 1));
      if ((i / 500) % 2 == 0) d = ($urandom_range(0, 7) == 0);
      else                    d = ($urandom_range(0, 199) == 0);
      cyc(s, a, r, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
